// File: rtl/window_centroid_stream_if.sv
// rtl/window_centroid_stream_if.sv - handshake/data bundle between FIFO/host and the centroid engine
// Purpose: groups the line-control inputs, FIFO read side and divider-side outputs.
// Ports (slave view = engine):
//   in : start_i, abort_i, mode_i, rdempty_i, data_i[DATA_W]
//   out: rd_fifo_o, aclr_fifo_o, numerator_o[NUM_W], denominator_o[DEN_W],
//        clken_o, den_zero_o, line_done_o, busy_o
interface window_centroid_stream_if #(
  parameter int DATA_W = 16,
  parameter int NUM_W  = 44,
  parameter int DEN_W  = 21
);
  logic              start_i;
  logic              abort_i;
  logic              mode_i;
  logic              rdempty_i;
  logic [DATA_W-1:0] data_i;
  logic              rd_fifo_o;
  logic              aclr_fifo_o;
  logic [NUM_W-1:0]  numerator_o;
  logic [DEN_W-1:0]  denominator_o;
  logic              clken_o;
  logic              den_zero_o;
  logic              line_done_o;
  logic              busy_o;

  modport master (
    output start_i, abort_i, mode_i, rdempty_i, data_i,
    input  rd_fifo_o, aclr_fifo_o, numerator_o, denominator_o,
           clken_o, den_zero_o, line_done_o, busy_o
  );

  modport slave (
    input  start_i, abort_i, mode_i, rdempty_i, data_i,
    output rd_fifo_o, aclr_fifo_o, numerator_o, denominator_o,
           clken_o, den_zero_o, line_done_o, busy_o
  );
endinterface

// File: rtl/window_centroid_stream.sv
// rtl/window_centroid_stream.sv - sliding-window centroid (numerator/denominator) engine
// Purpose: reads one line of LINE_LEN samples from a 1-cycle-latency FIFO and, once WIN samples
//   are held, emits one (SCALE*weighted sum, window sum) pair per sample.
// Ports:
//   clk_200MHz_i  system clock
//   reset_n       asynchronous active-low reset
//   bus (slave)   control inputs, FIFO read side, divider-side outputs
module window_centroid_stream #(
  parameter int DATA_W   = 16,
  parameter int WIN      = 19,
  parameter int LINE_LEN = 512,
  parameter int IDX_W    = 10,
  parameter int SCALE    = 10000,
  parameter int NUM_W    = 44,
  parameter int DEN_W    = 21
) (
  input logic                    clk_200MHz_i,
  input logic                    reset_n,
  window_centroid_stream_if.slave bus
);
  localparam int CNT_W = IDX_W + 1;
  localparam int PTR_W = $clog2(WIN);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE, S_CLEAR} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_clr_cnt;
  logic              r_mode;
  logic [CNT_W-1:0]  r_rd_cnt;

  // stage D: read issued, FIFO q arrives next cycle
  logic              r_vd;
  logic [IDX_W-1:0]  r_kd;
  // stage A: sample captured together with the sample leaving the window
  logic              r_va;
  logic [IDX_W-1:0]  r_ka;
  logic [DATA_W-1:0] r_xa, r_xold;
  logic [DATA_W-1:0] r_win [WIN];
  logic [PTR_W-1:0]  r_ptr;
  // stage B: running sums
  logic              r_vb;
  logic [IDX_W-1:0]  r_kb;
  logic [DEN_W-1:0]  r_den;
  logic [NUM_W-1:0]  r_num;

  logic              w_rd, w_abort, w_flush, w_pulse;
  logic [NUM_W-1:0]  w_num_nxt;

  assign w_rd    = (r_state == S_RUN) && !bus.rdempty_i && (r_rd_cnt < CNT_W'(LINE_LEN));
  assign w_abort = bus.abort_i && (r_state != S_IDLE);
  // abort and CLEAR both wipe the pipeline so the next line starts from an all-zero window
  assign w_flush = w_abort || (r_state == S_CLEAR);
  assign w_pulse = r_vb && (r_kb >= IDX_W'(WIN - 1));

  assign bus.rd_fifo_o   = w_rd;
  assign bus.aclr_fifo_o = (r_state == S_CLEAR);
  assign bus.line_done_o = (r_state == S_DONE);
  assign bus.busy_o      = (r_state != S_IDLE);

  always_ff @(posedge clk_200MHz_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_clr_cnt <= 1'b0;
      r_mode    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= (r_state == S_CLEAR) ? ~r_clr_cnt : 1'b0;
      if (r_state == S_IDLE && bus.start_i && !bus.abort_i)
        r_mode <= bus.mode_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_i && !bus.abort_i) w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.abort_i)
          w_state_nxt = S_CLEAR;
        else if (w_rd && r_rd_cnt == CNT_W'(LINE_LEN - 1))
          w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (bus.abort_i)
          w_state_nxt = S_CLEAR;
        else if (!r_vd && !r_va && !r_vb)
          w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_clr_cnt) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Relative mode: every weight drops by one as the window slides (subtract the old window sum
  // minus the departing sample, which had weight 0) and the new sample enters at weight WIN-1.
  always_comb begin
    w_num_nxt = '0;
    if (r_mode) begin
      w_num_nxt = r_num - (NUM_W'(r_den) - NUM_W'(r_xold)) + NUM_W'(r_xa) * NUM_W'(WIN - 1);
    end else begin
      w_num_nxt = r_num + NUM_W'(r_xa) * NUM_W'(r_ka);
      // departing sample index is ka-WIN; before the window fills xold is 0 anyway
      if (r_ka >= IDX_W'(WIN))
        w_num_nxt = w_num_nxt - NUM_W'(r_xold) * NUM_W'(r_ka - IDX_W'(WIN));
    end
  end

  always_ff @(posedge clk_200MHz_i or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_cnt <= '0;
      r_vd     <= 1'b0;
      r_kd     <= '0;
      r_va     <= 1'b0;
      r_ka     <= '0;
      r_xa     <= '0;
      r_xold   <= '0;
      r_ptr    <= '0;
      r_vb     <= 1'b0;
      r_kb     <= '0;
      r_den    <= '0;
      r_num    <= '0;
      for (int i = 0; i < WIN; i++) r_win[i] <= '0;
    end else if (w_flush) begin
      r_rd_cnt <= '0;
      r_vd     <= 1'b0;
      r_kd     <= '0;
      r_va     <= 1'b0;
      r_ka     <= '0;
      r_xa     <= '0;
      r_xold   <= '0;
      r_ptr    <= '0;
      r_vb     <= 1'b0;
      r_kb     <= '0;
      r_den    <= '0;
      r_num    <= '0;
      for (int i = 0; i < WIN; i++) r_win[i] <= '0;
    end else begin
      r_vd <= w_rd;
      if (w_rd) begin
        r_kd     <= r_rd_cnt[IDX_W-1:0];
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      r_va <= r_vd;
      if (r_vd) begin
        r_xa         <= bus.data_i;
        r_ka         <= r_kd;
        r_xold       <= r_win[r_ptr];
        r_win[r_ptr] <= bus.data_i;
        r_ptr        <= (r_ptr == PTR_W'(WIN - 1)) ? '0 : r_ptr + 1'b1;
      end
      r_vb <= r_va;
      if (r_va) begin
        r_kb  <= r_ka;
        r_den <= r_den + DEN_W'(r_xa) - DEN_W'(r_xold);
        r_num <= w_num_nxt;
      end
    end
  end

  always_ff @(posedge clk_200MHz_i or negedge reset_n) begin
    if (!reset_n) begin
      bus.clken_o       <= 1'b0;
      bus.den_zero_o    <= 1'b0;
      bus.numerator_o   <= '0;
      bus.denominator_o <= '0;
    end else if (w_flush) begin
      bus.clken_o       <= 1'b0;
      bus.den_zero_o    <= 1'b0;
      bus.numerator_o   <= '0;
      bus.denominator_o <= '0;
    end else begin
      bus.clken_o    <= w_pulse;
      bus.den_zero_o <= w_pulse && (r_den == '0);
      if (w_pulse) begin
        bus.numerator_o   <= r_num * NUM_W'(SCALE);
        bus.denominator_o <= r_den;
      end
    end
  end
endmodule

// File: tb/tb_window_centroid_stream.sv
// tb/tb_window_centroid_stream.sv - self-checking bench for window_centroid_stream
module tb_window_centroid_stream;
  localparam int DATA_W = 16, WIN = 19, LINE_LEN = 512, IDX_W = 10;
  localparam int SCALE = 10000, NUM_W = 44, DEN_W = 21;
  localparam int NPULSE = LINE_LEN - WIN + 1;
  localparam int P_ONE = 0, P_IMP = 1, P_K = 2, P_FF = 3;

  typedef struct {
    int     mode;
    int     pat;
    int     stall_at;
    int     stall_len;
    int     zeros;
    longint f_num;
    longint f_den;
    longint l_num;
    longint l_den;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_centroid_stream_if #(.DATA_W(DATA_W), .NUM_W(NUM_W), .DEN_W(DEN_W)) bus();

  window_centroid_stream #(
    .DATA_W(DATA_W), .WIN(WIN), .LINE_LEN(LINE_LEN), .IDX_W(IDX_W),
    .SCALE(SCALE), .NUM_W(NUM_W), .DEN_W(DEN_W)
  ) dut (
    .clk_200MHz_i(clk),
    .reset_n(rst_n),
    .bus(bus)
  );

  int total = 0, bad = 0;
  int cyc = 0;
  int rd_idx = 0, rd_cyc [LINE_LEN];
  int pulses = 0, zeros_seen = 0, done_cnt = 0, aclr_cnt = 0, rd_empty_viol = 0;
  int stall_at = 0, stall_len = 0, stall_cnt = 0;
  int cur_pat = 0, cur_mode = 0;
  longint first_num, first_den, last_num, last_den;
  logic pend = 1'b0;
  logic [DATA_W-1:0] data_nxt = '0;
  vec_t tbl [6];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint samp(input int pat, input int k);
    case (pat)
      P_ONE:   return 1;
      P_IMP:   return (k == 100) ? 1000 : 0;
      P_K:     return k;
      default: return 65535;
    endcase
  endfunction

  function automatic longint exp_den(input int n);
    longint s = 0;
    for (int k = n - WIN + 1; k <= n; k++) s += samp(cur_pat, k);
    return s;
  endfunction

  function automatic longint exp_num(input int n);
    longint s = 0;
    for (int k = n - WIN + 1; k <= n; k++)
      s += samp(cur_pat, k) * ((cur_mode != 0) ? longint'(k - (n - WIN + 1)) : longint'(k));
    return s * SCALE;
  endfunction

  always @(posedge clk) cyc++;

  // FIFO empty flag, changed just after the active edge
  always @(posedge clk) begin
    #1;
    if (stall_len > 0 && rd_idx >= stall_at && stall_cnt < stall_len) begin
      bus.rdempty_i = 1'b1;
      stall_cnt++;
    end else begin
      bus.rdempty_i = 1'b0;
    end
  end

  // FIFO q: valid the cycle after the read request
  always @(posedge clk) bus.data_i <= pend ? data_nxt : 16'h5A5A;

  // read tracking and output monitor, sampled mid-cycle
  always @(negedge clk) begin
    int n;
    if (bus.rd_fifo_o) begin
      if (bus.rdempty_i) rd_empty_viol++;
      if (rd_idx < LINE_LEN) rd_cyc[rd_idx] = cyc;
      data_nxt = DATA_W'(samp(cur_pat, rd_idx));
      pend = 1'b1;
      rd_idx++;
    end else begin
      pend = 1'b0;
    end
    if (bus.aclr_fifo_o) aclr_cnt++;
    if (bus.line_done_o) begin
      done_cnt++;
      check("done_after_last_pair", pulses, NPULSE);
    end
    if (bus.clken_o) begin
      n = pulses + WIN - 1;
      if (n < LINE_LEN) begin
        check("pair_den", longint'(bus.denominator_o), exp_den(n));
        check("pair_num", longint'(bus.numerator_o), exp_num(n));
        check("pair_den_zero", longint'(bus.den_zero_o), longint'(exp_den(n) == 0));
        check("pair_latency", cyc - rd_cyc[n], 4);
      end
      if (pulses == 0) begin
        first_num = longint'(bus.numerator_o);
        first_den = longint'(bus.denominator_o);
      end
      last_num = longint'(bus.numerator_o);
      last_den = longint'(bus.denominator_o);
      if (bus.den_zero_o) zeros_seen++;
      pulses++;
    end
  end

  task automatic new_line(input int pat, input int mode, input int s_at, input int s_len);
    cur_pat = pat; cur_mode = mode; rd_idx = 0;
    stall_at = s_at; stall_len = s_len; stall_cnt = 0;
    pulses = 0; zeros_seen = 0; done_cnt = 0; aclr_cnt = 0; rd_empty_viol = 0;
    first_num = -1; first_den = -1; last_num = -1; last_den = -1;
  endtask

  task automatic pulse_start(input int mode);
    @(posedge clk); #2;
    bus.mode_i = mode[0];
    bus.start_i = 1'b1;
    @(posedge clk); #2;
    bus.start_i = 1'b0;
    bus.mode_i = ~mode[0];  // mode must have been captured with start
  endtask

  task automatic wait_reads(input int target);
    int to = 0;
    while (rd_idx < target && to < 2000) begin @(posedge clk); #2; to++; end
    check("wait_reads_timeout", longint'(to < 2000), 1);
  endtask

  task automatic wait_idle(input string name);
    int to = 0;
    while (bus.busy_o && to < 4000) begin @(posedge clk); #2; to++; end
    check(name, longint'(to < 4000), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"}, longint'(bus.rd_fifo_o), 0);
    check({tag, "_aclr"}, longint'(bus.aclr_fifo_o), 0);
    check({tag, "_num"}, longint'(bus.numerator_o), 0);
    check({tag, "_den"}, longint'(bus.denominator_o), 0);
    check({tag, "_clken"}, longint'(bus.clken_o), 0);
    check({tag, "_zero"}, longint'(bus.den_zero_o), 0);
    check({tag, "_done"}, longint'(bus.line_done_o), 0);
    check({tag, "_busy"}, longint'(bus.busy_o), 0);
  endtask

  task automatic run_line(input vec_t v);
    new_line(v.pat, v.mode, v.stall_at, v.stall_len);
    pulse_start(v.mode);
    check("busy_after_start", longint'(bus.busy_o), 1);
    wait_idle("line_timeout");
    check("pulse_count", pulses, NPULSE);
    check("first_num", first_num, v.f_num);
    check("first_den", first_den, v.f_den);
    check("last_num", last_num, v.l_num);
    check("last_den", last_den, v.l_den);
    check("den_zero_count", zeros_seen, v.zeros);
    check("line_done_count", done_cnt, 1);
    check("aclr_cycles", aclr_cnt, 2);
    check("reads_total", rd_idx, LINE_LEN);
    check("read_while_empty", rd_empty_viol, 0);
    check("outputs_cleared_num", longint'(bus.numerator_o), 0);
    stall_len = 0;
  endtask

  initial begin
    int p0;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.mode_i = 1'b0;
    //        mode pat    stall_at len zeros first_num          first_den  last_num              last_den
    tbl[0] = '{0, P_ONE, 0,   0,  0,   64'd1_710_000,       64'd19,    64'd95_380_000,       64'd19};
    tbl[1] = '{1, P_ONE, 0,   0,  0,   64'd1_710_000,       64'd19,    64'd1_710_000,        64'd19};
    tbl[2] = '{1, P_IMP, 0,   0,  475, 64'd0,               64'd0,     64'd0,                64'd0};
    tbl[3] = '{0, P_K,   200, 50, 0,   64'd21_090_000,      64'd171,   64'd47_886_460_000,   64'd9538};
    tbl[4] = '{1, P_K,   0,   0,  0,   64'd21_090_000,      64'd171,   64'd864_120_000,      64'd9538};
    tbl[5] = '{0, P_FF,  0,   0,  0,   64'd112_064_850_000, 64'd1_245_165, 64'd6_250_728_300_000, 64'd1_245_165};

    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_line(tbl[i]);

    // abort mid-line, start during CLEAR ignored
    new_line(P_ONE, 0, 0, 0);
    pulse_start(0);
    wait_reads(300);
    bus.abort_i = 1'b1;
    @(posedge clk); #2;
    bus.abort_i = 1'b0;
    p0 = pulses;
    check("abort_clken_next", longint'(bus.clken_o), 0);
    check("abort_in_clear", longint'(bus.aclr_fifo_o), 1);
    bus.start_i = 1'b1;
    @(posedge clk); #2;
    bus.start_i = 1'b0;
    wait_idle("abort_timeout");
    check("abort_aclr_cycles", aclr_cnt, 2);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_pairs", pulses, p0);
    repeat (3) @(posedge clk);
    #2;
    check("start_in_clear_ignored", longint'(bus.busy_o), 0);

    // start together with abort in IDLE: abort wins
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    @(posedge clk); #2;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    check("start_abort_idle", longint'(bus.busy_o), 0);

    run_line(tbl[1]);

    // reset mid-line
    new_line(P_ONE, 0, 0, 0);
    pulse_start(0);
    wait_reads(300);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #2;
    check("midreset_no_aclr", aclr_cnt, 0);
    check("midreset_no_done", done_cnt, 0);
    rst_n = 1'b1;

    run_line(tbl[5]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
